prog_rom_responder: RTL and testbench



---
 rtl/prog_rom_responder.sv | 166 ++++++++++++++++
 tb/tb_prog_rom_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_rom_responder.sv
// rtl/prog_rom_responder.sv - CPU program memory with one-cycle fetch and framed byte-stream loader
// Frame: SYNC, ADR_H, ADR_L, LEN_H, LEN_L, then LEN data bytes written from ADR upward.
module prog_rom_responder #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MEM_AW    = 14,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  BUSY_FILL = 8'hFF
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [ADDR_W-1:0] ROM_ADDR_I,
  output logic [7:0]        ROM_DATA_O,
  input  logic              LD_VALID_I,
  input  logic [7:0]        LD_DATA_I,
  output logic              LD_READY_O,
  output logic              BUSY_O,
  output logic              DONE_O
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;
  localparam logic [13:0] ADDR_MASK = 14'((32'd1 << MEM_AW) - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR_H,
    ST_ADR_L,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA,
    ST_COMMIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [13:0] r_addr;
  logic [15:0] r_len;
  logic [7:0]  r_rom_data;
  logic [7:0]  r_mem [DEPTH];

  logic        w_ready;
  logic        w_busy;
  logic        w_done;
  logic        w_xfer;
  logic        w_wr_en;
  logic [13:0] w_addr_inc;
  logic        w_len_zero;

  assign w_xfer     = LD_VALID_I && w_ready;
  assign w_wr_en    = w_xfer && (r_state == ST_DATA);
  assign w_addr_inc = (r_addr + 14'd1) & ADDR_MASK;
  assign w_len_zero = ({r_len[15:8], LD_DATA_I} == 16'd0);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && (LD_DATA_I == SYNC_BYTE)) begin
          w_state_nxt = ST_ADR_H;
        end
      end
      ST_ADR_H: begin
        if (w_xfer) begin
          w_state_nxt = ST_ADR_L;
        end
      end
      ST_ADR_L: begin
        if (w_xfer) begin
          w_state_nxt = ST_LEN_H;
        end
      end
      ST_LEN_H: begin
        if (w_xfer) begin
          w_state_nxt = ST_LEN_L;
        end
      end
      ST_LEN_L: begin
        if (w_xfer) begin
          w_state_nxt = w_len_zero ? ST_COMMIT : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_xfer && (r_len == 16'd1)) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_ready = 1'b1;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
      end
      ST_COMMIT: begin
        w_ready = 1'b0;
        w_done  = 1'b1;
      end
      default: begin
        w_busy = 1'b1;
      end
    endcase
  end

  // Only the low six bits of the high address byte are meaningful.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_addr <= 14'd0;
      r_len  <= 16'd0;
    end else if (w_xfer) begin
      case (r_state)
        ST_ADR_H: r_addr <= {LD_DATA_I[5:0], r_addr[7:0]};
        ST_ADR_L: r_addr <= {r_addr[13:8], LD_DATA_I};
        ST_LEN_H: r_len  <= {LD_DATA_I, r_len[7:0]};
        ST_LEN_L: r_len  <= {r_len[15:8], LD_DATA_I};
        ST_DATA: begin
          r_addr <= w_addr_inc;
          r_len  <= r_len - 16'd1;
        end
        default: begin
          r_addr <= r_addr;
          r_len  <= r_len;
        end
      endcase
    end
  end

  // Array is never reset so a reset mid-load keeps already written bytes.
  always_ff @(posedge CLK_I) begin
    if (w_wr_en) begin
      r_mem[r_addr[MEM_AW-1:0]] <= LD_DATA_I;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_rom_data <= 8'd0;
    end else if (w_busy) begin
      r_rom_data <= BUSY_FILL;
    end else begin
      r_rom_data <= r_mem[ROM_ADDR_I[MEM_AW-1:0]];
    end
  end

  assign ROM_DATA_O = r_rom_data;
  assign LD_READY_O = w_ready;
  assign BUSY_O     = w_busy;
  assign DONE_O     = w_done;

endmodule

// File: tb/tb_prog_rom_responder.sv
// tb/tb_prog_rom_responder.sv - directed bench for prog_rom_responder
module tb_prog_rom_responder;

  logic        clk;
  logic        rst;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int done_snap;

  prog_rom_responder #(
    .ADDR_W(14),
    .MEM_AW(14),
    .SYNC_BYTE(8'hA5),
    .BUSY_FILL(8'hFF)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .ROM_ADDR_I(rom_addr),
    .ROM_DATA_O(rom_data),
    .LD_VALID_I(ld_valid),
    .LD_DATA_I(ld_data),
    .LD_READY_O(ld_ready),
    .BUSY_O(busy),
    .DONE_O(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    ld_valid = 1'b1;
    ld_data  = b;
    guard = 0;
    while (!ld_ready && guard < 8) begin
      tick();
      guard++;
    end
    if (!ld_ready) chk("ready_timeout", 32'(ld_ready), 32'd1);
    tick();
  endtask

  task automatic stop_valid();
    ld_valid = 1'b0;
    ld_data  = 8'h00;
  endtask

  task automatic fetch(input string tag, input logic [13:0] a, input logic [7:0] exp);
    rom_addr = a;
    tick();
    chk(tag, 32'(rom_data), 32'(exp));
  endtask

  initial begin
    rst      = 1'b1;
    rom_addr = 14'd0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    #12;
    chk("rst_rom_data", 32'(rom_data), 32'h00);
    chk("rst_ready",    32'(ld_ready), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Frame A5 00 10 00 03 11 22 33, valid held high.
    done_snap = n_done;
    send(8'hA5);
    chk("t1_busy_after_sync", 32'(busy), 32'd1);
    send(8'h00); send(8'h10); send(8'h00); send(8'h03);
    send(8'h11); send(8'h22);
    chk("t1_no_early_done", 32'(done), 32'd0);
    send(8'h33);
    stop_valid();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ready_commit", 32'(ld_ready), 32'd0);
    tick();
    chk("t1_done_fall", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_one_pulse", 32'(n_done - done_snap), 32'd1);
    fetch("t1_rd10", 14'h0010, 8'h11);
    fetch("t1_rd11", 14'h0011, 8'h22);
    fetch("t1_rd12", 14'h0012, 8'h33);

    // Address wrap, then high address bits 7:6 ignored.
    send(8'hA5); send(8'h3F); send(8'hFF); send(8'h00); send(8'h02);
    send(8'hAA); send(8'hBB);
    stop_valid();
    chk("t4_done", 32'(done), 32'd1);
    tick();
    fetch("t4_rd3fff", 14'h3FFF, 8'hAA);
    fetch("t4_rd0000", 14'h0000, 8'hBB);
    send(8'hA5); send(8'hFF); send(8'hFF); send(8'h00); send(8'h02);
    send(8'hCC); send(8'hDD);
    stop_valid();
    chk("t4b_done", 32'(done), 32'd1);
    tick();
    fetch("t4b_rd3fff", 14'h3FFF, 8'hCC);
    fetch("t4b_rd0000", 14'h0000, 8'hDD);

    // Junk before sync is discarded; gaps are tolerated.
    send(8'h00);
    chk("t2_busy_junk0", 32'(busy), 32'd0);
    send(8'h5A);
    chk("t2_busy_junk1", 32'(busy), 32'd0);
    send(8'hA5);
    chk("t2_busy_sync", 32'(busy), 32'd1);
    send(8'h00);
    stop_valid();
    tick(); tick();
    chk("t2_hold_busy", 32'(busy), 32'd1);
    send(8'h20); send(8'h00); send(8'h01); send(8'h77);
    stop_valid();
    chk("t2_done", 32'(done), 32'd1);
    tick();
    fetch("t2_rd20", 14'h0020, 8'h77);
    fetch("t2_rd00", 14'h0000, 8'hDD);

    // Zero-length frame commits straight from LEN_L.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    stop_valid();
    chk("t3_done", 32'(done), 32'd1);
    tick();
    chk("t3_idle", 32'(busy), 32'd0);
    fetch("t3_rd10", 14'h0010, 8'h11);
    fetch("t3_rd20", 14'h0020, 8'h77);
    fetch("t3_rd00", 14'h0000, 8'hDD);

    // Fetch during a frame returns the busy fill.
    rom_addr = 14'h0010;
    send(8'hA5);
    chk("t5_pre_busy", 32'(rom_data), 32'h11);
    send(8'h00);
    chk("t5_fill_adrl", 32'(rom_data), 32'hFF);
    send(8'h10);
    chk("t5_fill_lenh", 32'(rom_data), 32'hFF);
    send(8'h00); send(8'h01); send(8'h44);
    stop_valid();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_fill_commit", 32'(rom_data), 32'hFF);
    tick();
    chk("t5_done_fell", 32'(done), 32'd0);
    chk("t5_fill_last", 32'(rom_data), 32'hFF);
    tick();
    chk("t5_rd_after", 32'(rom_data), 32'h44);

    // Reset mid-frame keeps written bytes and never pulses DONE.
    done_snap = n_done;
    send(8'hA5); send(8'h00); send(8'h30); send(8'h00); send(8'h05);
    send(8'h01); send(8'h02);
    stop_valid();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy",  32'(busy),     32'd0);
    chk("t6_rst_ready", 32'(ld_ready), 32'd1);
    chk("t6_rst_done",  32'(done),     32'd0);
    chk("t6_rst_data",  32'(rom_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    fetch("t6_rd30", 14'h0030, 8'h01);
    fetch("t6_rd31", 14'h0031, 8'h02);
    chk("t6_no_done", 32'(n_done - done_snap), 32'd0);
    send(8'hA5); send(8'h00); send(8'h30); send(8'h00); send(8'h01);
    send(8'h09);
    stop_valid();
    chk("t6_refr_done", 32'(done), 32'd1);
    tick();
    fetch("t6_rd30_new", 14'h0030, 8'h09);
    fetch("t6_rd31_kept", 14'h0031, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
